// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the program loader: byte/word widths and the
//   loader FSM state encoding.
//   Used by: loader_word_assembler, program_loader.
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // The CSUM_* encodings are reserved in every build. They are only reachable
    // when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [3:0] {
        LEN_HI  = 4'd0,
        LEN_LO  = 4'd1,
        DATA_HI = 4'd2,
        DATA_LO = 4'd3,
        CSUM_HI = 4'd4,
        CSUM_LO = 4'd5,
        COMMIT  = 4'd6,
        RUN     = 4'd7,
        ERROR   = 4'd8
    } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler
//   Joins two big-endian bytes into one 16-bit word. The high byte is latched
//   when it is accepted. When the low byte is accepted, the word is presented
//   combinationally together with a one-cycle word_valid, so the caller can
//   act on it at the same clock edge.
// Ports
//   clk         in   1       system clock
//   accept_hi   in   1       high byte accepted this cycle
//   accept_lo   in   1       low byte accepted this cycle
//   byte_data   in   8       incoming byte
//   word        out  16      {latched high byte, byte_data}
//   word_valid  out  1       word is complete (low byte accepted this cycle)
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              accept_hi,
    input  logic              accept_lo,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [BYTE_W-1:0] hi_q;

    // hi_q is data only. It is always written before it is read, so it is not reset.
    always_ff @(posedge clk) begin
        if (accept_hi) begin
            hi_q <= byte_data;
        end
    end

    assign word       = {hi_q, byte_data};
    assign word_valid = accept_lo;

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader. It receives a program image as a byte stream over
//   valid/ready and writes 16-bit words into program memory starting at
//   address 0. The CPU is held (cpu_run=0) until the whole image is committed.
//   Stream format (big-endian): length L, then L data words, then an optional
//   checksum word.
// Configuration
//   LOADER_CHECKSUM_EN  when defined, a trailing checksum word (sum of the data
//                       words mod 2^16) is expected. A mismatch rejects the
//                       image. When undefined, the loader commits directly
//                       after the last data word.
// Parameters
//   DEPTH    number of program-memory words; an L greater than DEPTH is rejected
//   ADDR_W   width of prog_addr and of the length field
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       host byte valid
//   in_data    in   8       host byte
//   in_ready   out  1       loader can accept a byte (depends on state only)
//   prog_we    out  1       program-memory write strobe, one pulse per word
//   prog_addr  out  ADDR_W  word address for prog_we
//   prog_data  out  16      word data for prog_we
//   cpu_run    out  1       CPU may execute
//   done       out  1       image loaded and accepted (same as cpu_run)
//   err        out  1       image rejected; held until rst
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t POST_DATA = CSUM_HI;
`else
    localparam loader_state_t POST_DATA = COMMIT;
`endif

    loader_state_t state_q, state_d;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W:0]   idx_inc;
    logic              idx_last;
    logic              len_too_big;

    logic              accept;
    logic              accept_hi;
    logic              accept_lo;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              data_wr;

    logic              prog_we_q;
    logic [ADDR_W-1:0] prog_addr_q;
    logic [15:0]       prog_data_q;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q;
`endif

    // in_ready is decoded from the state only, so it never loops back from in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO: in_ready = 1'b1;
            default:                                            in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign accept_hi = accept & ((state_q == LEN_HI) | (state_q == DATA_HI) |
                                 (state_q == CSUM_HI));
    assign accept_lo = accept & ((state_q == LEN_LO) | (state_q == DATA_LO) |
                                 (state_q == CSUM_LO));

    loader_word_assembler u_asm (
        .clk        (clk),
        .accept_hi  (accept_hi),
        .accept_lo  (accept_lo),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign len_too_big = ({1'b0, word[ADDR_W-1:0]} > DEPTH_X);
    assign idx_inc     = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
    // The index is compared after incrementing, so it stops at L and never wraps.
    assign idx_last    = (idx_inc == {1'b0, len_q});
    assign data_wr     = word_valid & (state_q == DATA_LO);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN_HI:  if (accept) state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_too_big)                       state_d = ERROR;
                    else if (word[ADDR_W-1:0] == '0)       state_d = POST_DATA;
                    else                                   state_d = DATA_HI;
                end
            end
            DATA_HI: if (accept) state_d = DATA_LO;
            DATA_LO: begin
                if (accept) begin
                    state_d = idx_last ? POST_DATA : DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM_HI: if (accept) state_d = CSUM_LO;
            CSUM_LO: begin
                if (accept) begin
                    state_d = (word == sum_q) ? COMMIT : ERROR;
                end
            end
`endif
            // COMMIT lasts one cycle so that the final prog_we pulse lands
            // before the CPU is released.
            COMMIT:  state_d = RUN;
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LEN_HI;
            len_q       <= '0;
            idx_q       <= '0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else begin
            state_q   <= state_d;
            prog_we_q <= data_wr;
            if (word_valid && (state_q == LEN_LO)) begin
                len_q <= word[ADDR_W-1:0];
                idx_q <= '0;
            end
            if (data_wr) begin
                prog_addr_q <= idx_q;
                prog_data_q <= word;
                idx_q       <= idx_inc[ADDR_W-1:0];
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (word_valid && (state_q == LEN_LO)) begin
            sum_q <= '0;
        end else if (data_wr) begin
            sum_q <= sum_q + word;
        end
    end
`endif

    assign prog_we   = prog_we_q;
    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign cpu_run   = (state_q == RUN);
    assign done      = (state_q == RUN);
    assign err       = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader. Two instances share clk, rst and
//   in_data: dut (default DEPTH) and dut16 (DEPTH=16, used for the
//   length-limit cases). When LOADER_CHECKSUM_EN is defined, the images carry
//   a checksum word.
module tb_program_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  in_data;
    logic        v0, v1;

    logic        r0, we0, run0, done0, err0;
    logic [15:0] addr0, pdata0;
    logic        r1, we1, run1, done1, err1;
    logic [15:0] addr1, pdata1;

    program_loader dut (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(in_data), .in_ready(r0),
        .prog_we(we0), .prog_addr(addr0), .prog_data(pdata0),
        .cpu_run(run0), .done(done0), .err(err0)
    );

    program_loader #(.DEPTH(16), .ADDR_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(in_data), .in_ready(r1),
        .prog_we(we1), .prog_addr(addr1), .prog_data(pdata1),
        .cpu_run(run1), .done(done1), .err(err1)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [7:0]  seq_q[$];
    logic [15:0] exp_w[3] = '{16'h1234, 16'hABCD, 16'h0001};

    // Record every write of the main instance.
    always @(negedge clk) begin
        if (we0) begin
            wa_q.push_back(addr0);
            wd_q.push_back(pdata0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        wa_q.delete();
        wd_q.delete();
    endtask

    // Present one byte for exactly one cycle after `gap` idle cycles. The task
    // returns on the negedge that follows the accepting posedge.
    task automatic send(input logic sel, input logic [7:0] b, input int gap);
        v0 = 1'b0; v1 = 1'b0;
        repeat (gap) @(negedge clk);
        in_data = b;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic send_seq(input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++) begin
            send(1'b0, seq_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic build_image(input logic [15:0] csum);
        seq_q.delete();
        seq_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
`ifdef LOADER_CHECKSUM_EN
        seq_q.push_back(csum[15:8]);
        seq_q.push_back(csum[7:0]);
`else
        if (csum == 16'hFFFF) seq_q.push_back(8'h00); // never taken; keeps csum used
`endif
    endtask

    task automatic check_writes(input string tag);
        #1;
        check({tag, "_nwr"}, wa_q.size(), 3);
        for (int i = 0; i < wa_q.size() && i < 3; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wd_q[i], exp_w[i]);
        end
    endtask

    initial begin
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; in_data = 8'h00;

        // Reset state
        do_reset();
        check("rst_ready", r0, 1);
        check("rst_run", run0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_we", we0, 0);
        check("rst_addr", addr0, 0);
        check("rst_data", pdata0, 0);
        check("rst_ready16", r1, 1);

        // 3-word image, no gaps
        build_image(16'hBE02);
        send_seq(0, seq_q.size() - 1, 0);
        check("t1_run_commit", run0, 0);
        check("t1_rdy_commit", r0, 0);
        @(negedge clk);
        check("t1_run", run0, 1);
        check("t1_done", done0, 1);
        check("t1_err", err0, 0);
        repeat (2) @(negedge clk);
        check_writes("t1");
        check("t1_rdy_after", r0, 0);
        send(1'b0, 8'h55, 0);
        repeat (2) @(negedge clk);
        #1;
        check("t1_ignored_nwr", wa_q.size(), 3);
        check("t1_run_hold", run0, 1);

        // L = 0: empty image
        do_reset();
        seq_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        seq_q.push_back(8'h00);
        seq_q.push_back(8'h00);
`endif
        send_seq(0, seq_q.size() - 1, 0);
        check("t2_run_commit", run0, 0);
        check("t2_rdy_commit", r0, 0);
        @(negedge clk);
        check("t2_run", run0, 1);
        #1;
        check("t2_nwr", wa_q.size(), 0);

        // DEPTH=16 instance: L=17 rejected, L=16 accepted
        do_reset();
        send(1'b1, 8'h00, 0);
        send(1'b1, 8'h11, 0);
        check("t3_err", err1, 1);
        check("t3_rdy", r1, 0);
        check("t3_run", run1, 0);
        repeat (3) @(negedge clk);
        check("t3_err_hold", err1, 1);
        check("t3_run_hold", run1, 0);
        check("t3_done", done1, 0);
        check("t3_we", we1, 0);
        check("t3_addr", addr1, 0);
        check("t3_pdata", pdata1, 0);
        do_reset();
        send(1'b1, 8'h00, 0);
        send(1'b1, 8'h10, 0);
        check("t3_len16_err", err1, 0);
        check("t3_len16_rdy", r1, 1);

        // Same image with random in_valid gaps
        do_reset();
        build_image(16'hBE02);
        send_seq(0, seq_q.size() - 1, 5);
        check("t4_run_commit", run0, 0);
        @(negedge clk);
        check("t4_run", run0, 1);
        repeat (2) @(negedge clk);
        check_writes("t4");

        // Reset after the second data word, then a full reload
        do_reset();
        build_image(16'hBE02);
        send_seq(0, 5, 0);
        repeat (2) @(negedge clk);
        #1;
        check("t5_partial_nwr", wa_q.size(), 2);
        do_reset();
        check("t5_rst_run", run0, 0);
        check("t5_rst_rdy", r0, 1);
        send_seq(0, seq_q.size() - 2, 0);
        check("t5_run_early", run0, 0);
        send_seq(seq_q.size() - 1, seq_q.size() - 1, 0);
        check("t5_run_commit", run0, 0);
        @(negedge clk);
        check("t5_run", run0, 1);
        repeat (2) @(negedge clk);
        check_writes("t5");

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum
        do_reset();
        build_image(16'hBE03);
        send_seq(0, seq_q.size() - 1, 0);
        repeat (2) @(negedge clk);
        check("t6_err", err0, 1);
        check("t6_run", run0, 0);
        check("t6_rdy", r0, 0);
        check_writes("t6");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
